// File: rtl/dqam_pkg.sv
// Shared types, quadrant constants and Gray helpers for the square-QAM symbol mapper.
package dqam_pkg;

    localparam int MAX_BITS_PER_AXIS = 4;

    typedef logic [1:0] quad_t;

    localparam quad_t QUAD_PP = 2'd0;
    localparam quad_t QUAD_NP = 2'd1;
    localparam quad_t QUAD_NN = 2'd2;
    localparam quad_t QUAD_PN = 2'd3;

    // Indexed by {Isign, Qsign}: 00->+0, 01->+1, 10->+3, 11->+2
    localparam quad_t GRAY_INC [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

    function automatic logic [MAX_BITS_PER_AXIS-1:0] gray2bin(
        input logic [MAX_BITS_PER_AXIS-1:0] g
    );
        logic [MAX_BITS_PER_AXIS-1:0] b;
        b[MAX_BITS_PER_AXIS-1] = g[MAX_BITS_PER_AXIS-1];
        for (int k = MAX_BITS_PER_AXIS-2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/pam_gray_axis.sv
// One PAM axis: Gray magnitude plus sign to an odd signed level (2b+1), combinational.
module pam_gray_axis
    import dqam_pkg::*;
#(
    parameter int OUT_W = 3
) (
    input  logic                         neg_i,
    input  logic [MAX_BITS_PER_AXIS-1:0] gray_i,
    output logic signed [OUT_W-1:0]      level_o
);

    logic [MAX_BITS_PER_AXIS:0] odd;
    logic [OUT_W-1:0]           mag;

    assign odd     = {gray2bin(gray_i), 1'b1};
    assign mag     = OUT_W'(odd);
    assign level_o = neg_i ? OUT_W'(-mag) : mag;

endmodule

// File: rtl/dqam_symbol_mapper.sv
// Serial-bit to square-QAM I/Q symbol mapper with optional differential quadrant coding.
// Optional delivered-symbol counter is built when DQAM_SYM_COUNT_EN is defined.
module dqam_symbol_mapper
    import dqam_pkg::*;
#(
    parameter int BITS_PER_AXIS = 2,
    parameter int OUT_W         = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    input  logic                    diff_en,
    input  logic                    sym_clr,
    output logic signed [OUT_W-1:0] sym_i,
    output logic signed [OUT_W-1:0] sym_q,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic [15:0]             sym_count
);

    localparam int SYM_BITS = 2 * BITS_PER_AXIS;
    localparam int CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_BITS - 1);
    localparam logic [MAX_BITS_PER_AXIS-1:0] GMASK =
        MAX_BITS_PER_AXIS'((1 << (BITS_PER_AXIS - 1)) - 1);

    logic [CNT_W-1:0]    count_q, count_d;
    logic [SYM_BITS-2:0] shift_q, shift_d;
    quad_t               quad_q, quad_d;
    logic signed [OUT_W-1:0] sym_i_q, sym_i_d, sym_q_q, sym_q_d;
    logic                sym_valid_q, sym_valid_d;

    logic                last, accept, complete;
    logic [SYM_BITS-1:0] word;
    logic                i_sign, q_sign, i_neg, q_neg;
    quad_t               quad_abs, quad_new;
    logic [MAX_BITS_PER_AXIS-1:0] i_gray, q_gray;
    logic signed [OUT_W-1:0] lvl_i, lvl_q;

    always_comb begin
        last      = (count_q == LAST);
        bit_ready = !sym_clr && (!last || !sym_valid_q || sym_ready);
        accept    = bit_valid && bit_ready;
        complete  = accept && last;
        word      = {shift_q, bit_in};
        i_sign    = word[SYM_BITS-1];
        q_sign    = word[BITS_PER_AXIS-1];
        i_gray    = MAX_BITS_PER_AXIS'(word[SYM_BITS-1 -: BITS_PER_AXIS]) & GMASK;
        q_gray    = MAX_BITS_PER_AXIS'(word[BITS_PER_AXIS-1:0]) & GMASK;
        case ({i_sign, q_sign})
            2'b00:   quad_abs = QUAD_PP;
            2'b10:   quad_abs = QUAD_NP;
            2'b11:   quad_abs = QUAD_NN;
            default: quad_abs = QUAD_PN;
        endcase
        quad_new = diff_en ? quad_t'(quad_q + GRAY_INC[{i_sign, q_sign}]) : quad_abs;
        i_neg    = (quad_new == QUAD_NP) || (quad_new == QUAD_NN);
        q_neg    = (quad_new == QUAD_NN) || (quad_new == QUAD_PN);
    end

    pam_gray_axis #(.OUT_W(OUT_W)) u_axis_i (.neg_i(i_neg), .gray_i(i_gray), .level_o(lvl_i));
    pam_gray_axis #(.OUT_W(OUT_W)) u_axis_q (.neg_i(q_neg), .gray_i(q_gray), .level_o(lvl_q));

    always_comb begin
        count_d     = count_q;
        shift_d     = shift_q;
        quad_d      = quad_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        sym_valid_d = sym_valid_q;

        if (sym_clr) begin
            count_d = '0;
            shift_d = '0;
            quad_d  = QUAD_PP;
        end else if (accept) begin
            shift_d = word[SYM_BITS-2:0];
            count_d = last ? '0 : count_q + CNT_W'(1);
            if (last) quad_d = quad_new;
        end

        // A completing word reloads the output even while the old symbol is being handed off
        if (complete) begin
            sym_i_d     = lvl_i;
            sym_q_d     = lvl_q;
            sym_valid_d = 1'b1;
        end else if (sym_valid_q && sym_ready) begin
            sym_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q     <= '0;
            shift_q     <= '0;
            quad_q      <= QUAD_PP;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            shift_q     <= shift_d;
            quad_q      <= quad_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign sym_i     = sym_i_q;
    assign sym_q     = sym_q_q;
    assign sym_valid = sym_valid_q;

`ifdef DQAM_SYM_COUNT_EN
    logic [15:0] sym_count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sym_count_q <= '0;
        end else if (sym_valid_q && sym_ready) begin
            sym_count_q <= sym_count_q + 16'd1;
        end
    end

    assign sym_count = sym_count_q;
`else
    assign sym_count = '0;
`endif

endmodule

// File: tb/tb_dqam_symbol_mapper.sv
// Scoreboard bench for dqam_symbol_mapper: a B=2 instance plus a B=1 (QPSK) instance.
module tb_dqam_symbol_mapper;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    logic bit_in = 1'b0, bit_valid = 1'b0, diff_en = 1'b0, sym_clr = 1'b0, sym_ready = 1'b1;
    logic bit_ready, sym_valid;
    logic signed [2:0] sym_i, sym_q;
    logic [15:0] sym_count;

    logic b_bit_in = 1'b0, b_bit_valid = 1'b0, b_diff_en = 1'b0, b_sym_clr = 1'b0, b_sym_ready = 1'b1;
    logic b_bit_ready, b_sym_valid;
    logic signed [1:0] b_sym_i, b_sym_q;
    logic [15:0] b_sym_count;

    int errors = 0;
    int checks = 0;
    int hs_a = 0;
    int hs_b = 0;
    logic [5:0] q_a[$];
    logic [3:0] q_b[$];

    always #5 CLK = ~CLK;

    dqam_symbol_mapper #(.BITS_PER_AXIS(2), .OUT_W(3)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .diff_en(diff_en), .sym_clr(sym_clr), .sym_i(sym_i), .sym_q(sym_q),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_count(sym_count)
    );

    dqam_symbol_mapper #(.BITS_PER_AXIS(1), .OUT_W(2)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .bit_in(b_bit_in), .bit_valid(b_bit_valid), .bit_ready(b_bit_ready),
        .diff_en(b_diff_en), .sym_clr(b_sym_clr), .sym_i(b_sym_i), .sym_q(b_sym_q),
        .sym_valid(b_sym_valid), .sym_ready(b_sym_ready), .sym_count(b_sym_count)
    );

    function automatic logic [5:0] pk3(input int i, input int q);
        return {3'(i), 3'(q)};
    endfunction

    function automatic logic [3:0] pk2(input int i, input int q);
        return {2'(i), 2'(q)};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitors sample mid-low-phase, after all drives have settled
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge CLK); #2;
            if (RST_N && sym_valid && sym_ready) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL sb_a unexpected symbol: got (%0d,%0d)", sym_i, sym_q);
                end else begin
                    e = q_a.pop_front();
                    if ({sym_i, sym_q} !== e) begin
                        errors++;
                        $display("FAIL sb_a symbol: got (%0d,%0d) expected (%0d,%0d)",
                                 sym_i, sym_q, $signed(e[5:3]), $signed(e[2:0]));
                    end
                end
                hs_a++;
            end
        end
    end

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge CLK); #2;
            if (RST_N && b_sym_valid && b_sym_ready) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL sb_b unexpected symbol: got (%0d,%0d)", b_sym_i, b_sym_q);
                end else begin
                    e = q_b.pop_front();
                    if ({b_sym_i, b_sym_q} !== e) begin
                        errors++;
                        $display("FAIL sb_b symbol: got (%0d,%0d) expected (%0d,%0d)",
                                 b_sym_i, b_sym_q, $signed(e[3:2]), $signed(e[1:0]));
                    end
                end
                hs_b++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        int t;
        t = 0;
        bit_in = b;
        bit_valid = 1'b1;
        #1;
        while (!bit_ready && t < 50) begin
            @(negedge CLK); #1;
            t++;
        end
        if (!bit_ready) check("bit_ready_timeout", 0, 1);
        @(posedge CLK);
        @(negedge CLK);
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int k = n-1; k >= 0; k--) send_bit(w[k]);
    endtask

    task automatic send_word(input logic [3:0] w, input logic [5:0] e);
        q_a.push_back(e);
        send_bits({4'b0, w}, 4);
    endtask

    task automatic send_bit_b(input logic b);
        int t;
        t = 0;
        b_bit_in = b;
        b_bit_valid = 1'b1;
        #1;
        while (!b_bit_ready && t < 50) begin
            @(negedge CLK); #1;
            t++;
        end
        if (!b_bit_ready) check("b_bit_ready_timeout", 0, 1);
        @(posedge CLK);
        @(negedge CLK);
        b_bit_valid = 1'b0;
    endtask

    task automatic send_word_b(input logic [1:0] w, input logic [3:0] e);
        q_b.push_back(e);
        send_bit_b(w[1]);
        send_bit_b(w[0]);
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || sym_valid || b_sym_valid) && t < 100) begin
            @(negedge CLK); #3;
            t++;
        end
        if (t >= 100) check({nm, "_idle_timeout"}, 0, 1);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_sym_i", int'(sym_i), 0);
        check("rst_sym_q", int'(sym_q), 0);
        check("rst_sym_count", int'(sym_count), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst_bit_ready", int'(bit_ready), 1);
        @(negedge CLK);

        // 1: absolute mapping, latency of one cycle
        diff_en = 1'b0;
        send_word(4'b0000, pk3(1, 1));
        #1;
        check("t1_valid_latency", int'(sym_valid), 1);
        send_word(4'b1111, pk3(-3, -3));
        wait_idle("t1");

        // 2: differential rotation from a fresh reset
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        hs_a = 0;
        hs_b = 0;
        diff_en = 1'b1;
        send_word(4'b0010, pk3(-1, 1));
        send_word(4'b0010, pk3(-1, -1));
        send_word(4'b0010, pk3(1, -1));
        send_word(4'b1010, pk3(-1, 1));
        wait_idle("t2");

        // 3: backpressure holds the symbol and blocks the completing bit
        diff_en = 1'b0;
        sym_ready = 1'b0;
        send_word(4'b0101, pk3(3, 3));
        q_a.push_back(pk3(-1, 1));
        send_bits(8'b0000_0100, 3);
        bit_in = 1'b0;
        bit_valid = 1'b1;
        #1;
        check("t3_bit_ready_blocked", int'(bit_ready), 0);
        repeat (3) begin
            @(negedge CLK); #1;
            check("t3_hold", int'({sym_valid, sym_i, sym_q}), int'({1'b1, pk3(3, 3)}));
        end
        @(negedge CLK);
        sym_ready = 1'b1;
        #1;
        check("t3_bit_ready_released", int'(bit_ready), 1);
        @(posedge CLK);
        @(negedge CLK);
        bit_valid = 1'b0;
        #1;
        check("t3_back_to_back", int'({sym_valid, sym_i, sym_q}), int'({1'b1, pk3(-1, 1)}));
        wait_idle("t3");

        // 4: sym_clr flushes partial word and phase reference (quad was 1)
        send_bits(8'b0000_0011, 2);
        sym_clr = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b1;
        #1;
        check("t4_bit_ready_clr", int'(bit_ready), 0);
        @(posedge CLK);
        @(negedge CLK);
        sym_clr = 1'b0;
        bit_valid = 1'b0;
        diff_en = 1'b1;
        send_word(4'b0010, pk3(-1, 1));
        wait_idle("t4");

        // 5: async reset mid-word clears a held symbol immediately
        diff_en = 1'b0;
        sym_ready = 1'b0;
        send_bits(8'b0000_1111, 4);
        send_bits(8'b0000_0000, 2);
        #1;
        check("t5_pre_valid", int'(sym_valid), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("t5_rst_valid", int'(sym_valid), 0);
        check("t5_rst_i", int'(sym_i), 0);
        check("t5_rst_q", int'(sym_q), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        hs_a = 0;
        hs_b = 0;
        sym_ready = 1'b1;
        diff_en = 1'b1;
        send_word(4'b0010, pk3(-1, 1));
        wait_idle("t5");

        // 6: QPSK instance, five handshakes
        b_diff_en = 1'b0;
        send_word_b(2'b10, pk2(-1, 1));
        send_word_b(2'b00, pk2(1, 1));
        send_word_b(2'b11, pk2(-1, -1));
        send_word_b(2'b01, pk2(1, -1));
        send_word_b(2'b10, pk2(-1, 1));
        wait_idle("t6");
        @(negedge CLK); #3;

`ifdef DQAM_SYM_COUNT_EN
        check("sym_count_a", int'(sym_count), hs_a);
        check("sym_count_b", int'(b_sym_count), 5);
`else
        check("sym_count_a", int'(sym_count), 0);
        check("sym_count_b", int'(b_sym_count), 0);
`endif
        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
